// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared types and default widths for the decoder correction path.
//   err_kind_t    : error classification produced by the syndrome decoder
//   DEC_CW_WIDTH  : default codeword width
//   DEC_CNT_WIDTH : default status counter width
// -----------------------------------------------------------------------------
package dec_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10,
        ERR_RSVD   = 2'b11
    } err_kind_t;

    localparam int DEC_CW_WIDTH  = 32;
    localparam int DEC_CNT_WIDTH = 16;

endpackage

// File: rtl/dec_flip_mask.sv
// -----------------------------------------------------------------------------
// dec_flip_mask
// Combinational one-hot mask generator for single-bit correction.
//   err_pos_i  : index of the bit to invert
//   mask_o     : one-hot mask with bit err_pos_i set (all zero if out of range)
//   in_range_o : err_pos_i addresses a real codeword bit
// -----------------------------------------------------------------------------
module dec_flip_mask #(
    parameter int CW_WIDTH  = 32,
    parameter int POS_WIDTH = $clog2(CW_WIDTH)
) (
    input  logic [POS_WIDTH-1:0] err_pos_i,
    output logic [CW_WIDTH-1:0]  mask_o,
    output logic                 in_range_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < CW_WIDTH; i++) begin
            mask_o[i] = (err_pos_i == POS_WIDTH'(i));
        end
    end

    // Positions beyond the last bit decode to an all-zero mask, so the
    // range test falls out of the decode for free.
    assign in_range_o = |mask_o;

endmodule

// File: rtl/dec_correct_stage.sv
// -----------------------------------------------------------------------------
// dec_correct_stage
// Single-bit correction stage with a one-deep registered valid/ready output
// and saturating status counters.
//   clk, rst                : clock, asynchronous active-low reset
//   in_valid/in_ready       : upstream handshake
//   codeword/err_kind/err_pos : received word and syndrome classification
//   out_valid/out_ready     : downstream handshake
//   data_out                : corrected codeword
//   corrected/uncorrectable : per-beat status flags
//   out_pos                 : flipped bit index (0 when nothing flipped)
//   cnt_clear               : synchronous clear of both counters
//   corr_cnt/uncorr_cnt     : saturating counts of accepted flagged beats
// -----------------------------------------------------------------------------
module dec_correct_stage
    import dec_pkg::*;
#(
    parameter int CW_WIDTH  = DEC_CW_WIDTH,
    parameter int POS_WIDTH = $clog2(CW_WIDTH),
    parameter int CNT_WIDTH = DEC_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW_WIDTH-1:0]  codeword,
    input  logic [1:0]           err_kind,
    input  logic [POS_WIDTH-1:0] err_pos,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW_WIDTH-1:0]  data_out,
    output logic                 corrected,
    output logic                 uncorrectable,
    output logic [POS_WIDTH-1:0] out_pos,
    input  logic                 cnt_clear,
    output logic [CNT_WIDTH-1:0] corr_cnt,
    output logic [CNT_WIDTH-1:0] uncorr_cnt
);

    logic                 valid_q,  valid_d;
    logic [CW_WIDTH-1:0]  data_q,   data_d;
    logic                 corr_q,   corr_d;
    logic                 unc_q,    unc_d;
    logic [POS_WIDTH-1:0] pos_q,    pos_d;
    logic [CNT_WIDTH-1:0] ccnt_q,   ccnt_d;
    logic [CNT_WIDTH-1:0] ucnt_q,   ucnt_d;

    logic [CW_WIDTH-1:0]  flip_mask;
    logic                 pos_in_range;
    logic                 in_acc;
    err_kind_t            kind;

    dec_flip_mask #(
        .CW_WIDTH  (CW_WIDTH),
        .POS_WIDTH (POS_WIDTH)
    ) u_flip_mask (
        .err_pos_i  (err_pos),
        .mask_o     (flip_mask),
        .in_range_o (pos_in_range)
    );

    assign kind     = err_kind_t'(err_kind);
    assign in_ready = !valid_q || out_ready;
    assign in_acc   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        corr_d  = corr_q;
        unc_d   = unc_q;
        pos_d   = pos_q;
        if (in_acc) begin
            valid_d = 1'b1;
            data_d  = codeword;
            corr_d  = 1'b0;
            unc_d   = 1'b0;
            pos_d   = '0;
            case (kind)
                ERR_NONE: ;
                ERR_SINGLE: begin
                    if (pos_in_range) begin
                        data_d = codeword ^ flip_mask;
                        corr_d = 1'b1;
                        pos_d  = err_pos;
                    end else begin
                        unc_d = 1'b1;
                    end
                end
                default: unc_d = 1'b1;
            endcase
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // corr_d/unc_d equal the flags being loaded whenever in_acc is set.
    always_comb begin
        ccnt_d = ccnt_q;
        ucnt_d = ucnt_q;
        if (cnt_clear) begin
            ccnt_d = '0;
            ucnt_d = '0;
        end else if (in_acc) begin
            if (corr_d && (ccnt_q != '1)) ccnt_d = ccnt_q + CNT_WIDTH'(1);
            if (unc_d  && (ucnt_q != '1)) ucnt_d = ucnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            corr_q  <= 1'b0;
            unc_q   <= 1'b0;
            pos_q   <= '0;
            ccnt_q  <= '0;
            ucnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            corr_q  <= corr_d;
            unc_q   <= unc_d;
            pos_q   <= pos_d;
            ccnt_q  <= ccnt_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign data_out      = data_q;
    assign corrected     = corr_q;
    assign uncorrectable = unc_q;
    assign out_pos       = pos_q;
    assign corr_cnt      = ccnt_q;
    assign uncorr_cnt    = ucnt_q;

endmodule

// File: tb/tb_dec_correct_stage.sv
// -----------------------------------------------------------------------------
// tb_dec_correct_stage
// Self-checking bench: a 32-bit instance driven from a vector table through a
// scoreboard, plus a 22-bit instance (out-of-range position) and a 2-bit
// counter instance (saturation and clear priority).
// -----------------------------------------------------------------------------
module tb_dec_correct_stage;

    typedef struct {
        logic [31:0] cw;
        logic [1:0]  kind;
        logic [4:0]  pos;
        logic [31:0] e_data;
        logic        e_corr;
        logic        e_unc;
        logic [4:0]  e_pos;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- 32-bit instance ----------------
    vec_t        cur;
    logic        in_valid, in_ready, out_valid, out_ready, cnt_clear;
    logic [31:0] data_out;
    logic        corrected, uncorrectable;
    logic [4:0]  out_pos;
    logic [15:0] corr_cnt, uncorr_cnt;

    dec_correct_stage dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .codeword(cur.cw), .err_kind(cur.kind), .err_pos(cur.pos),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .corrected(corrected), .uncorrectable(uncorrectable),
        .out_pos(out_pos), .cnt_clear(cnt_clear),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    // ---------------- 22-bit instance ----------------
    logic        v22, r22, ov22;
    logic [21:0] cw22, do22;
    logic [1:0]  ek22;
    logic [4:0]  ep22, op22;
    logic        c22, u22;
    logic [15:0] cc22, uc22;

    dec_correct_stage #(.CW_WIDTH(22)) dut22 (
        .clk(clk), .rst(rst),
        .in_valid(v22), .in_ready(r22),
        .codeword(cw22), .err_kind(ek22), .err_pos(ep22),
        .out_valid(ov22), .out_ready(1'b1),
        .data_out(do22), .corrected(c22), .uncorrectable(u22),
        .out_pos(op22), .cnt_clear(1'b0),
        .corr_cnt(cc22), .uncorr_cnt(uc22)
    );

    // ---------------- 2-bit counter instance ----------------
    logic        vc, rc, ovc, clrc;
    logic [31:0] doc;
    logic [1:0]  ekc;
    logic [4:0]  epc, opc;
    logic        cc, uc;
    logic [1:0]  ccc, ucc;

    dec_correct_stage #(.CNT_WIDTH(2)) dutc2 (
        .clk(clk), .rst(rst),
        .in_valid(vc), .in_ready(rc),
        .codeword(32'h0000_FFFF), .err_kind(ekc), .err_pos(epc),
        .out_valid(ovc), .out_ready(1'b1),
        .data_out(doc), .corrected(cc), .uncorrectable(uc),
        .out_pos(opc), .cnt_clear(clrc),
        .corr_cnt(ccc), .uncorr_cnt(ucc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard and counter model (32-bit) ----------------
    vec_t        exp_q[$];
    logic [15:0] m_corr, m_unc;

    always @(negedge clk) begin
        vec_t e;
        if (!rst) begin
            exp_q.delete();
            m_corr = '0;
            m_unc  = '0;
        end else begin
            check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
            check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_unc));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %h expected no beat", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", data_out, e.e_data);
                    check("corrected", 32'(corrected), 32'(e.e_corr));
                    check("uncorrectable", 32'(uncorrectable), 32'(e.e_unc));
                    check("out_pos", 32'(out_pos), 32'(e.e_pos));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur);
            if (cnt_clear) begin
                m_corr = '0;
                m_unc  = '0;
            end else if (in_valid && in_ready) begin
                if (cur.e_corr && m_corr != 16'hFFFF) m_corr = m_corr + 16'd1;
                if (cur.e_unc  && m_unc  != 16'hFFFF) m_unc  = m_unc  + 16'd1;
            end
        end
    end

    task automatic send(input vec_t v);
        @(posedge clk); #1;
        cur      = v;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    vec_t tbl[8];
    vec_t va, vb;
    int   exp5[5];
    logic [15:0] corr_before;

    initial begin
        tbl[0] = '{32'hA5A5_A5A5, 2'b01, 5'd0,  32'hA5A5_A5A4, 1'b1, 1'b0, 5'd0};
        tbl[1] = '{32'h0000_0000, 2'b01, 5'd31, 32'h8000_0000, 1'b1, 1'b0, 5'd31};
        tbl[2] = '{32'h1234_5678, 2'b10, 5'd0,  32'h1234_5678, 1'b0, 1'b1, 5'd0};
        tbl[3] = '{32'h1234_5678, 2'b11, 5'd7,  32'h1234_5678, 1'b0, 1'b1, 5'd0};
        tbl[4] = '{32'hDEAD_BEEF, 2'b00, 5'd5,  32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0};
        tbl[5] = '{32'hFFFF_FFFF, 2'b01, 5'd16, 32'hFFFE_FFFF, 1'b1, 1'b0, 5'd16};
        tbl[6] = '{32'h0F0F_0F0F, 2'b01, 5'd4,  32'h0F0F_0F1F, 1'b1, 1'b0, 5'd4};
        tbl[7] = '{32'h8000_0001, 2'b10, 5'd31, 32'h8000_0001, 1'b0, 1'b1, 5'd0};
        exp5   = '{1, 2, 3, 3, 3};

        rst = 1'b0;
        cur = tbl[4];
        in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
        v22 = 1'b0; cw22 = '0; ek22 = 2'b00; ep22 = '0;
        vc = 1'b0; ekc = 2'b00; epc = '0; clrc = 1'b0;

        // reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_flags", {30'd0, corrected, uncorrectable}, 32'd0);
        check("rst_out_pos", 32'(out_pos), 32'd0);
        check("rst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // table: back-to-back beats at full throughput
        for (int i = 0; i < 8; i++) begin
            send(tbl[i]);
            check("throughput_in_ready", 32'(in_ready), 32'd1);
        end
        idle();
        drain();
        check("table_corr_cnt", 32'(corr_cnt), 32'd4);
        check("table_uncorr_cnt", 32'(uncorr_cnt), 32'd3);

        // backpressure: A held 3 cycles while B waits, then both move on one edge
        va = '{32'h5555_0000, 2'b10, 5'd0, 32'h5555_0000, 1'b0, 1'b1, 5'd0};
        vb = '{32'h0000_0000, 2'b01, 5'd3, 32'h0000_0008, 1'b1, 1'b0, 5'd3};
        send(va);
        @(posedge clk); #1;
        cur = vb;
        out_ready = 1'b0;
        corr_before = corr_cnt;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", data_out, va.e_data);
            check("bp_hold_unc", 32'(uncorrectable), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_b_loaded", data_out, vb.e_data);
        check("bp_b_counted_once", 32'(corr_cnt), 32'(corr_before + 16'd1));
        drain();

        // counter clear on the 32-bit instance coinciding with a flagged beat
        send(tbl[5]);
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; cnt_clear = 1'b0;
        check("clear_wins_corr", 32'(corr_cnt), 32'd0);
        check("clear_wins_unc", 32'(uncorr_cnt), 32'd0);
        drain();

        // 22-bit instance: out-of-range and in-range single errors
        @(posedge clk); #1;
        v22 = 1'b1; cw22 = 22'h3F_FFFF; ek22 = 2'b01; ep22 = 5'd25;
        @(posedge clk); #1;
        ep22 = 5'd21;
        check("w22_oor_valid", 32'(ov22), 32'd1);
        check("w22_oor_data", 32'(do22), 32'h003F_FFFF);
        check("w22_oor_flags", {30'd0, c22, u22}, 32'd1);
        check("w22_oor_pos", 32'(op22), 32'd0);
        check("w22_oor_ucnt", 32'(uc22), 32'd1);
        @(posedge clk); #1;
        v22 = 1'b0;
        check("w22_msb_data", 32'(do22), 32'h001F_FFFF);
        check("w22_msb_flags", {30'd0, c22, u22}, 32'd2);
        check("w22_msb_pos", 32'(op22), 32'd21);
        check("w22_msb_ccnt", 32'(cc22), 32'd1);

        // 2-bit counters: saturation, then clear beats a coincident increment
        @(posedge clk); #1;
        vc = 1'b1; ekc = 2'b01; epc = 5'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("sat_corr_cnt", 32'(ccc), 32'(exp5[i]));
        end
        clrc = 1'b1;
        @(posedge clk); #1;
        vc = 1'b0; clrc = 1'b0;
        check("sat_clear", 32'(ccc), 32'd0);

        // asynchronous reset while a beat is held under backpressure
        out_ready = 1'b0;
        send(va);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_counters", {corr_cnt, uncorr_cnt}, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        out_ready = 1'b1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_no_beat", 32'(out_valid), 32'd0);
        send(tbl[0]);
        idle();
        check("rel_data", data_out, 32'hA5A5_A5A4);
        check("rel_corr_cnt", 32'(corr_cnt), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_correct_stage.md
Name: dec_correct_stage

Overview:
Parametrised, pipelined single-bit correction stage for the decoder path. It takes a received codeword plus the syndrome decoder's error classification and bit position, and inverts the indicated bit when the error is correctable. Results are registered behind a valid/ready handshake, and saturating event counters are kept for status reporting. It sits between the syndrome decoder and the data-extraction stage.

Parameters:
CW_WIDTH, 32, codeword width in bits (>= 2; need not be a power of 2).
POS_WIDTH, $clog2(CW_WIDTH), width of the error-position field (derived; not overridden).
CNT_WIDTH, 16, width of each event counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low.
in_valid  input  1  input beat is valid.
in_ready  output  1  stage can accept a beat.
codeword  input  CW_WIDTH  received codeword.
err_kind  input  2  error class: 00 none, 01 single, 10 double, 11 reserved.
err_pos  input  POS_WIDTH  index of the erroneous bit (meaningful only for single).
out_valid  output  1  output beat is valid.
out_ready  input  1  downstream accepts the beat.
data_out  output  CW_WIDTH  corrected codeword.
corrected  output  1  a bit was flipped in this beat.
uncorrectable  output  1  this beat could not be corrected.
out_pos  output  POS_WIDTH  err_pos of this beat if corrected, else 0.
cnt_clear  input  1  synchronous clear of both counters.
corr_cnt  output  CNT_WIDTH  count of accepted beats with corrected=1.
uncorr_cnt  output  CNT_WIDTH  count of accepted beats with uncorrectable=1.

Behaviour:
- Reset (rst=0, async): out_valid, data_out, corrected, uncorrectable, out_pos, corr_cnt and uncorr_cnt all go to 0. in_ready reads 1 while in reset and immediately after reset release.
- in_ready = !out_valid || out_ready (combinational). Input accept = in_valid && in_ready. Output accept = out_valid && out_ready.
- Latency is 1 cycle. A beat accepted at edge N appears on the outputs after edge N, with out_valid=1.
- Full throughput: with out_ready held at 1, one beat is accepted every cycle.
- On input accept, the registers load data_out, corrected, uncorrectable and out_pos as follows:
  - err_kind=00: codeword passes through; corrected=0, uncorrectable=0.
  - err_kind=01 and err_pos < CW_WIDTH: data_out = codeword with bit err_pos inverted; corrected=1.
  - err_kind=01 and err_pos >= CW_WIDTH: codeword passes through unmodified; uncorrectable=1. This case is possible only when CW_WIDTH is not a power of 2.
  - err_kind=10 or 11: codeword passes through; uncorrectable=1.
  - Outputs are never driven to X or Z.
- If out_valid=1 and out_ready=0 and no input accept occurs, all output registers hold.
- If an output accept occurs with no input accept, out_valid goes to 0. data_out and the flags retain their values but are don't-care.
- Counters:
  - Each counter increments by 1 on input accept when the corresponding flag is being loaded as 1.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - cnt_clear=1 zeroes both counters on the next edge. When a clear and an increment coincide, clear wins and the result is 0.
- Reset asserted mid-stream discards any held beat: out_valid=0 and counters=0. No partial beat is produced after release.

Decomposition:
- Package dec_pkg:
  - typedef err_kind_t (enum ERR_NONE=2'b00, ERR_SINGLE=2'b01, ERR_DOUBLE=2'b10, ERR_RSVD=2'b11).
  - Default widths DEC_CW_WIDTH=32 and DEC_CNT_WIDTH=16.
- Sub-module dec_flip_mask: combinational, parameter CW_WIDTH. It produces a one-hot CW_WIDTH mask from err_pos, plus an in_range flag. The top level XORs the mask into codeword. The handshake, registers and counters remain in dec_correct_stage.

Test Plan:
1. CW_WIDTH=32, out_ready=1; codeword=32'hA5A5_A5A5, err_kind=01, err_pos=0 -> next cycle data_out=32'hA5A5_A5A4, corrected=1, out_pos=0, corr_cnt=1.
2. CW_WIDTH=32; err_pos=31, codeword=32'h0000_0000, then err_kind=10 with codeword=32'h1234_5678 in back-to-back cycles -> data_out=32'h8000_0000 with corrected=1, then 32'h1234_5678 with uncorrectable=1. One beat per cycle, corr_cnt=1, uncorr_cnt=1.
3. CW_WIDTH=22; err_kind=01, err_pos=25, codeword=22'h3F_FFFF -> data_out=22'h3F_FFFF, uncorrectable=1, corrected=0, out_pos=0.
4. Backpressure: accept beat A, then hold out_ready=0 for 3 cycles with in_valid=1 presenting beat B -> in_ready=0 and A is stable for 3 cycles. Raise out_ready -> A is accepted, B loads on the same edge, and counters count B exactly once.
5. CNT_WIDTH=2; 5 consecutive single-error beats -> corr_cnt reads 1,2,3,3,3. Then cnt_clear=1 together with a single-error beat -> corr_cnt=0.
6. Assert rst=0 asynchronously mid-cycle while out_valid=1 and out_ready=0 -> out_valid and counters drop to 0 immediately, without waiting for an edge. After release, in_ready=1 and the next beat behaves as in scenario 1.
